// File: rtl/rect_compositor.sv
// Rectangle compositor: per-pixel hit test of NUM_OBJ signed boxes, lowest index wins; optional collision flags via RECT_COMPOSITOR_COLLIDE_EN.
// Latency: results appear 2 i_pix_stb strobes after the i_x/i_y sample; both stages hold between strobes.
// Backpressure: none; i_pix_stb is the only advance qualifier, and collision flags update only on i_animate.
module rect_compositor #(
    parameter int                   NUM_OBJ  = 4,
    parameter int                   COORD_W  = 12,
    parameter int                   COLOR_W  = 8,
    parameter logic [COLOR_W-1:0]   BG_COLOR = {COLOR_W{1'b0}},
    parameter int                   IDX_W    = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_pix_stb,
    input  logic [9:0]                     i_x,
    input  logic [8:0]                     i_y,
    input  logic                           i_animate,
    input  logic [NUM_OBJ-1:0]             i_obj_en,
    input  logic [NUM_OBJ*4*COORD_W-1:0]   i_obj_box,
    input  logic [NUM_OBJ*COLOR_W-1:0]     i_obj_color,
    output logic [COLOR_W-1:0]             o_color,
    output logic                           o_hit,
    output logic [IDX_W-1:0]               o_hit_idx,
    output logic [NUM_OBJ-1:0]             o_collide,
    output logic                           o_collide_irq
);

    // Pixel position zero-extended by one bit so it compares as a non-negative signed value.
    logic signed [COORD_W:0] px;
    logic signed [COORD_W:0] py;
    assign px = signed'((COORD_W+1)'(i_x));
    assign py = signed'((COORD_W+1)'(i_y));

    logic [NUM_OBJ-1:0] hit_d;

    genvar k;
    generate
        for (k = 0; k < NUM_OBJ; k++) begin : g_obj
            localparam int BASE = k*4*COORD_W;
            logic signed [COORD_W:0] x1, x2, y1, y2;
            assign x1 = {i_obj_box[BASE+1*COORD_W-1], i_obj_box[BASE+0*COORD_W +: COORD_W]};
            assign x2 = {i_obj_box[BASE+2*COORD_W-1], i_obj_box[BASE+1*COORD_W +: COORD_W]};
            assign y1 = {i_obj_box[BASE+3*COORD_W-1], i_obj_box[BASE+2*COORD_W +: COORD_W]};
            assign y2 = {i_obj_box[BASE+4*COORD_W-1], i_obj_box[BASE+3*COORD_W +: COORD_W]};
            // Strict bounds make empty or inverted boxes unreachable without a separate check.
            assign hit_d[k] = i_obj_en[k] && (px > x1) && (px < x2) && (py > y1) && (py < y2);
        end
    endgenerate

    // Stage 1: hit vector plus a colour snapshot, so later colour edits do not leak into in-flight pixels.
    logic [NUM_OBJ-1:0]         hit_q;
    logic [NUM_OBJ*COLOR_W-1:0] col_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_q <= '0;
            col_q <= '0;
        end else if (i_pix_stb) begin
            hit_q <= hit_d;
            col_q <= i_obj_color;
        end
    end

    logic               win_hit;
    logic [IDX_W-1:0]   win_idx;
    logic [COLOR_W-1:0] win_col;

    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        win_col = BG_COLOR;
        for (int i = NUM_OBJ-1; i >= 0; i--) begin
            if (hit_q[i]) begin
                win_hit = 1'b1;
                win_idx = IDX_W'(i);
                win_col = col_q[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage 2: registered composite outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_color   <= BG_COLOR;
            o_hit     <= 1'b0;
            o_hit_idx <= '0;
        end else if (i_pix_stb) begin
            o_color   <= win_col;
            o_hit     <= win_hit;
            o_hit_idx <= win_idx;
        end
    end

`ifdef RECT_COMPOSITOR_COLLIDE_EN
    logic [NUM_OBJ-1:0] coll_now;
    logic [NUM_OBJ-1:0] pend_q;
    logic [NUM_OBJ-1:0] coll_load;
    logic               any_pair;

    // Only pairs involving object 0 count; bit 0 summarises that any such pair occurred.
    always_comb begin
        coll_now = '0;
        any_pair = 1'b0;
        if (i_pix_stb && hit_d[0]) begin
            for (int j = 1; j < NUM_OBJ; j++) begin
                coll_now[j] = hit_d[j];
                any_pair    = any_pair | hit_d[j];
            end
        end
        coll_now[0] = any_pair;
    end

    assign coll_load = pend_q | coll_now;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q        <= '0;
            o_collide     <= '0;
            o_collide_irq <= 1'b0;
        end else if (i_animate) begin
            o_collide     <= coll_load;
            o_collide_irq <= |coll_load;
            pend_q        <= '0;
        end else begin
            o_collide_irq <= 1'b0;
            pend_q        <= coll_load;
        end
    end
`else
    logic unused_animate;
    assign unused_animate = i_animate;
    assign o_collide      = '0;
    assign o_collide_irq  = 1'b0;
`endif

endmodule
